// File: rtl/cordic_job_controller.sv
// Job-level sequencer for the CORDIC core: accepts one job, loads the core,
// issues single-step enables with the right shift index (hyperbolic repeats at
// 4 and 13), stops early on overflow and presents the final state on a
// valid/ready result port. One job in flight at a time.
module cordic_job_controller #(
   parameter int p_WIDTH     = 32,
   parameter int p_ITER_BITS = 5,
   parameter int p_MAX_ITER  = 30
) (
   input  logic                   clk,
   input  logic                   rstn,
   // job request
   input  logic                   i_job_valid,
   output logic                   o_job_ready,
   input  logic [p_WIDTH-1:0]     i_job_x,
   input  logic [p_WIDTH-1:0]     i_job_y,
   input  logic [p_WIDTH-1:0]     i_job_z,
   input  logic                   i_job_system,
   input  logic                   i_job_mode,
   input  logic [p_ITER_BITS-1:0] i_job_iter,
   // result
   output logic                   o_res_valid,
   input  logic                   i_res_ready,
   output logic [p_WIDTH-1:0]     o_res_x,
   output logic [p_WIDTH-1:0]     o_res_y,
   output logic [p_WIDTH-1:0]     o_res_z,
   output logic                   o_res_overflow,
   output logic [p_ITER_BITS-1:0] o_res_iter_done,
   output logic                   o_busy,
   // core control
   output logic                   o_core_load,
   output logic                   o_core_en,
   output logic [p_WIDTH-1:0]     o_core_x,
   output logic [p_WIDTH-1:0]     o_core_y,
   output logic [p_WIDTH-1:0]     o_core_z,
   output logic                   o_core_system,
   output logic                   o_core_mode,
   output logic [p_ITER_BITS-1:0] o_core_shift,
   input  logic [p_WIDTH-1:0]     i_core_x,
   input  logic [p_WIDTH-1:0]     i_core_y,
   input  logic [p_WIDTH-1:0]     i_core_z,
   input  logic                   i_core_overflow
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_WAIT, S_DONE} state_t;

   typedef struct packed {
      logic [p_WIDTH-1:0] x;
      logic [p_WIDTH-1:0] y;
      logic [p_WIDTH-1:0] z;
      logic               system;
      logic               mode;
   } job_t;

   localparam logic [p_ITER_BITS-1:0] MAX_N = p_ITER_BITS'(p_MAX_ITER);
   // hyperbolic CORDIC needs these indices repeated to converge
   localparam logic [p_ITER_BITS-1:0] REP_A = p_ITER_BITS'(4);
   localparam logic [p_ITER_BITS-1:0] REP_B = p_ITER_BITS'(13);

   state_t                 state, state_nx;
   job_t                   job_q;
   logic [p_ITER_BITS-1:0] n_q, steps_q, shift_q;
   logic                   rep_q;     // current hyperbolic repeat index already issued once
   logic [p_WIDTH-1:0]     res_x_q, res_y_q, res_z_q;
   logic                   res_ovf_q;
   logic [p_ITER_BITS-1:0] res_iter_q;
   logic                   finish;    // WAIT resolves to DONE this cycle
   logic                   repeat_now;

   assign finish     = i_core_overflow || (steps_q == n_q);
   assign repeat_now = !job_q.system && !rep_q && ((shift_q == REP_A) || (shift_q == REP_B));

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (i_job_valid) state_nx = S_LOAD;
         S_LOAD: state_nx = (n_q == '0) ? S_WAIT : S_ITER;
         S_ITER: state_nx = S_WAIT;
         S_WAIT: state_nx = finish ? S_DONE : S_ITER;
         S_DONE: if (i_res_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // state register, job latch, step/shift counters and result capture
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= S_IDLE;
         job_q      <= '0;
         n_q        <= '0;
         steps_q    <= '0;
         shift_q    <= '0;
         rep_q      <= 1'b0;
         res_x_q    <= '0;
         res_y_q    <= '0;
         res_z_q    <= '0;
         res_ovf_q  <= 1'b0;
         res_iter_q <= '0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: if (i_job_valid) begin
               job_q   <= '{x: i_job_x, y: i_job_y, z: i_job_z,
                            system: i_job_system, mode: i_job_mode};
               n_q     <= (i_job_iter > MAX_N) ? MAX_N : i_job_iter;
               steps_q <= '0;
               shift_q <= i_job_system ? p_ITER_BITS'(0) : p_ITER_BITS'(1);
               rep_q   <= 1'b0;
            end
            S_ITER: steps_q <= steps_q + 1'b1;
            S_WAIT: begin
               if (finish) begin
                  // core state is valid now (cycle after the last load/en)
                  res_x_q    <= i_core_x;
                  res_y_q    <= i_core_y;
                  res_z_q    <= i_core_z;
                  res_ovf_q  <= i_core_overflow;
                  res_iter_q <= steps_q;
               end else if (repeat_now) begin
                  rep_q <= 1'b1;
               end else begin
                  shift_q <= shift_q + 1'b1;
                  rep_q   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_job_ready     = (state == S_IDLE);
   assign o_busy          = (state != S_IDLE);
   assign o_core_load     = (state == S_LOAD);
   assign o_core_en       = (state == S_ITER);
   assign o_core_shift    = shift_q;
   assign o_core_x        = job_q.x;
   assign o_core_y        = job_q.y;
   assign o_core_z        = job_q.z;
   assign o_core_system   = job_q.system;
   assign o_core_mode     = job_q.mode;
   assign o_res_valid     = (state == S_DONE);
   assign o_res_x         = res_x_q;
   assign o_res_y         = res_y_q;
   assign o_res_z         = res_z_q;
   assign o_res_overflow  = res_ovf_q;
   assign o_res_iter_done = res_iter_q;

endmodule

// File: tb/tb_cordic_job_controller.sv
// Directed bench for cordic_job_controller with a behavioural CORDIC core model.
module tb_cordic_job_controller;
   localparam int W  = 32;
   localparam int IB = 5;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          i_job_valid = 1'b0, o_job_ready;
   logic [W-1:0]  i_job_x = '0, i_job_y = '0, i_job_z = '0;
   logic          i_job_system = 1'b0, i_job_mode = 1'b0;
   logic [IB-1:0] i_job_iter = '0;
   logic          o_res_valid, i_res_ready = 1'b1;
   logic [W-1:0]  o_res_x, o_res_y, o_res_z;
   logic          o_res_overflow;
   logic [IB-1:0] o_res_iter_done;
   logic          o_busy, o_core_load, o_core_en, o_core_system, o_core_mode;
   logic [W-1:0]  o_core_x, o_core_y, o_core_z;
   logic [IB-1:0] o_core_shift;
   logic signed [W-1:0] cx = '0, cy = '0, cz = '0;
   logic          ovf = 1'b0;

   int checks = 0, errors = 0;
   int en_job = 0, en_total = 0, ov_at = 0;
   logic [IB-1:0] shift_log [0:255];

   cordic_job_controller dut (
      .clk(clk), .rstn(rstn),
      .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
      .i_job_x(i_job_x), .i_job_y(i_job_y), .i_job_z(i_job_z),
      .i_job_system(i_job_system), .i_job_mode(i_job_mode), .i_job_iter(i_job_iter),
      .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
      .o_res_x(o_res_x), .o_res_y(o_res_y), .o_res_z(o_res_z),
      .o_res_overflow(o_res_overflow), .o_res_iter_done(o_res_iter_done), .o_busy(o_busy),
      .o_core_load(o_core_load), .o_core_en(o_core_en),
      .o_core_x(o_core_x), .o_core_y(o_core_y), .o_core_z(o_core_z),
      .o_core_system(o_core_system), .o_core_mode(o_core_mode), .o_core_shift(o_core_shift),
      .i_core_x(cx), .i_core_y(cy), .i_core_z(cz), .i_core_overflow(ovf)
   );

   always #5 clk = ~clk;

   // atan(2^-i) in full-scale angle units (2^32 = 360 deg)
   function automatic logic signed [W-1:0] atan_tab(input int i);
      case (i)
         0: return 32'h2000_0000;
         1: return 32'h12E4_051E;
         2: return 32'h09FB_385B;
         3: return 32'h0511_11D4;
         4: return 32'h028B_0D43;
         5: return 32'h0145_D7E1;
         6: return 32'h00A2_F61E;
         7: return 32'h0051_7C55;
         8: return 32'h0028_BE53;
         9: return 32'h0014_5F2F;
         default: return 32'(683565276 >> i);
      endcase
   endfunction

   // behavioural core: load / one iteration per enable, overflow after en number ov_at
   always @(posedge clk) begin : core_model
      logic signed [W-1:0] xs, ys, at;
      logic d;
      xs = cx >>> o_core_shift;
      ys = cy >>> o_core_shift;
      at = atan_tab(int'(o_core_shift));
      d  = o_core_mode ? ~cz[W-1] : cy[W-1];
      if (o_core_load) begin
         cx <= o_core_x; cy <= o_core_y; cz <= o_core_z;
         en_job <= 0;
      end else if (o_core_en) begin
         if (o_core_system) begin
            if (d) begin cx <= cx - ys; cy <= cy + xs; cz <= cz - at; end
            else   begin cx <= cx + ys; cy <= cy - xs; cz <= cz + at; end
         end else begin
            if (d) begin cx <= cx + ys; cy <= cy + xs; cz <= cz - at; end
            else   begin cx <= cx - ys; cy <= cy - xs; cz <= cz + at; end
         end
         en_job <= en_job + 1;
      end
      ovf <= o_core_en && (ov_at != 0) && (en_job + 1 == ov_at);
      if (o_core_en) begin
         shift_log[en_total & 255] <= o_core_shift;
         en_total <= en_total + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_near(input string tag, input longint obs, input longint exp, input longint tol);
      checks++;
      assert ((obs - exp <= tol) && (exp - obs <= tol)) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
      end
   endtask

   task automatic start_job(input logic [W-1:0] x, y, z, input logic sys, mode,
                            input logic [IB-1:0] iter);
      chk("job_ready_before_accept", 64'(o_job_ready), 64'd1);
      i_job_x = x; i_job_y = y; i_job_z = z;
      i_job_system = sys; i_job_mode = mode; i_job_iter = iter;
      i_job_valid = 1'b1;
      tick();
      i_job_valid = 1'b0;
   endtask

   // cycles counted from the accept cycle (= 0)
   task automatic wait_res(output int cyc);
      cyc = 1;
      while (o_res_valid !== 1'b1 && cyc < 200) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      int cyc, base, k;
      logic [W-1:0] rx, ry, rz;
      logic [IB-1:0] exp_hyp [0:14];
      exp_hyp = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                  5'd10, 5'd11, 5'd12, 5'd13, 5'd13};

      // reset state
      tick(); tick();
      chk("reset_flags", 64'({o_job_ready, o_res_valid, o_busy, o_core_load, o_core_en,
                              o_res_overflow, o_core_system, o_core_mode}), 64'h80);
      chk("reset_res_xy", {o_res_x, o_res_y}, 64'd0);
      chk("reset_res_z_core_x", {o_res_z, o_core_x}, 64'd0);
      chk("reset_iter_shift", 64'({o_res_iter_done, o_core_shift}), 64'd0);
      rstn = 1'b1;
      tick();

      // T1 circular rotation by 45 deg, 10 iterations
      base = en_total;
      start_job(32'h4DBA_76D4, 32'h0, 32'h2000_0000, 1'b1, 1'b1, 5'd10);
      wait_res(cyc);
      chk("t1_latency", 64'(cyc), 64'd22);
      chk_near("t1_x", longint'($signed(o_res_x)), 64'sd1518500250, 64'sd4194304);
      chk_near("t1_y", longint'($signed(o_res_y)), 64'sd1518500250, 64'sd4194304);
      chk_near("t1_z", longint'($signed(o_res_z)), 64'sd0, 64'sd2386093);
      chk("t1_ovf_iter", 64'({o_res_overflow, o_res_iter_done}), 64'd10);
      for (int i = 0; i < 10; i++) chk($sformatf("t1_shift%0d", i), 64'(shift_log[(base + i) & 255]), 64'(i));
      tick();
      chk("t1_valid_drop", 64'({o_res_valid, o_job_ready}), 64'b01);

      // T2 hyperbolic shift order, 6 then 15 iterations
      base = en_total;
      start_job(32'h4000_0000, 32'h1000_0000, 32'h0, 1'b0, 1'b0, 5'd6);
      wait_res(cyc);
      chk("t2a_latency", 64'(cyc), 64'd14);
      chk("t2a_en_count", 64'(en_total - base), 64'd6);
      for (int i = 0; i < 6; i++) chk($sformatf("t2a_shift%0d", i), 64'(shift_log[(base + i) & 255]), 64'(exp_hyp[i]));
      tick();
      base = en_total;
      start_job(32'h4000_0000, 32'h1000_0000, 32'h0, 1'b0, 1'b0, 5'd15);
      wait_res(cyc);
      chk("t2b_en_count", 64'(en_total - base), 64'd15);
      for (int i = 0; i < 15; i++) chk($sformatf("t2b_shift%0d", i), 64'(shift_log[(base + i) & 255]), 64'(exp_hyp[i]));
      chk("t2b_iter_done", 64'(o_res_iter_done), 64'd15);
      tick();

      // T3 overflow after the 3rd step
      ov_at = 3;
      base = en_total;
      start_job(32'h2000_0000, 32'h0, 32'h1000_0000, 1'b1, 1'b1, 5'd10);
      wait_res(cyc);
      chk("t3_latency", 64'(cyc), 64'd8);
      chk("t3_en_count", 64'(en_total - base), 64'd3);
      chk("t3_ovf_iter", 64'({o_res_overflow, o_res_iter_done}), 64'h23);
      tick();
      ov_at = 0;

      // T4 backpressure and iteration clamp
      i_res_ready = 1'b0;
      base = en_total;
      start_job(32'h4DBA_76D4, 32'h0, 32'h1000_0000, 1'b1, 1'b1, 5'd31);
      wait_res(cyc);
      chk("t4_latency", 64'(cyc), 64'd62);
      chk("t4_en_count", 64'(en_total - base), 64'd30);
      chk("t4_ovf_iter", 64'({o_res_overflow, o_res_iter_done}), 64'd30);
      chk("t4_capture_xy", {o_res_x, o_res_y}, {cx, cy});
      chk("t4_capture_z", 64'(o_res_z), 64'(cz));
      rx = o_res_x; ry = o_res_y; rz = o_res_z;
      i_job_valid = 1'b1;
      i_job_x = 32'h1234_5678; i_job_iter = 5'd2;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_hold_xy", {o_res_x, o_res_y}, {rx, ry});
         chk("t4_hold_z_iter", {o_res_z, 27'd0, o_res_iter_done}, {rz, 32'd30});
         chk("t4_hold_flags", 64'({o_res_valid, o_job_ready, o_busy}), 64'b101);
      end
      i_job_valid = 1'b0;
      i_res_ready = 1'b1;
      tick();
      chk("t4_release", 64'({o_res_valid, o_job_ready, o_busy}), 64'b010);
      chk("t4_no_extra_en", 64'(en_total - base), 64'd30);

      // T5 reset mid-job, then a zero-iteration job
      base = en_total;
      start_job(32'h3000_0000, 32'h0, 32'h0800_0000, 1'b1, 1'b1, 5'd10);
      k = 0;
      while ((en_total - base) < 4 && k < 50) begin
         tick();
         k++;
      end
      chk("t5_reached_4th_en", 64'(en_total - base), 64'd4);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      chk("t5_reset_flags", 64'({o_job_ready, o_res_valid, o_busy, o_core_load, o_core_en,
                                 o_res_overflow, o_core_system, o_core_mode}), 64'h80);
      chk("t5_reset_core_xy", {o_core_x, o_core_y}, 64'd0);
      chk("t5_reset_shift", 64'(o_core_shift), 64'd0);
      start_job(32'h0AAA_5555, 32'hF000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 5'd0);
      wait_res(cyc);
      chk("t5_latency", 64'(cyc), 64'd3);
      chk("t5_res_xy", {o_res_x, o_res_y}, 64'h0AAA_5555_F000_0001);
      chk("t5_res_z_iter", {o_res_z, 27'd0, o_res_iter_done}, 64'h7FFF_FFFF_0000_0000);
      chk("t5_en_count", 64'(en_total - base), 64'd4);
      tick();
      chk("t5_idle", 64'({o_res_valid, o_job_ready}), 64'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
